rtc_sequencer: RTL and testbench

Transaction sequencer for the multiplexed-bus RTC controller. It sits on both sides of the bus-cycle FSM: it issues `do_it`/`w_r` requests and drives the address/data byte onto the shared A/D bus when the FSM raises `send_add`/`send_data`. It also captures the read byte while `read_data` is high. It scans the six time/date registers on request into a local shadow bank, and runs single user-requested writes between scans.

---
 rtl/rtc_sequencer_if.sv | 37 +++
 rtl/rtc_sequencer.sv | 152 +++++++++++++++
 tb/tb_rtc_sequencer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_sequencer_if.sv
// rtl/rtc_sequencer_if.sv - request, bus-cycle and shadow-register signals of the RTC sequencer
interface rtc_sequencer_if;
  logic       scan_req;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       send_add;
  logic       send_data;
  logic       read_data;
  logic [7:0] ad_in;
  logic       do_it;
  logic       w_r;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic [7:0] sec;
  logic [7:0] min;
  logic [7:0] hour;
  logic [7:0] day;
  logic [7:0] month;
  logic [7:0] year;
  logic       scan_done;
  logic       wr_ack;
  logic       wr_pend;
  logic       busy;

  modport master (
    input  scan_req, wr_req, wr_addr, wr_data, send_add, send_data, read_data, ad_in,
    output do_it, w_r, ad_out, ad_oe, sec, min, hour, day, month, year,
    output scan_done, wr_ack, wr_pend, busy
  );

  modport slave (
    output scan_req, wr_req, wr_addr, wr_data, send_add, send_data, read_data, ad_in,
    input  do_it, w_r, ad_out, ad_oe, sec, min, hour, day, month, year,
    input  scan_done, wr_ack, wr_pend, busy
  );
endinterface

// File: rtl/rtc_sequencer.sv
// rtl/rtc_sequencer.sv - scans six RTC time/date registers into shadows and runs single writes
module rtc_sequencer #(
  parameter int         TXN_CYCLES = 36,
  parameter logic [7:0] BASE_ADDR  = 8'h21
) (
  input  logic              clk,
  input  logic              reset,
  rtc_sequencer_if.master   bus
);
  localparam int            CW       = $clog2(TXN_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(TXN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state_q, state_d;
  logic          scan_pend_q, scan_pend_d;
  logic          wr_pend_q, wr_pend_d;
  logic [7:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          w_r_q, w_r_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    cap_q, cap_d;
  logic [7:0]    shadow_q [6];
  logic [7:0]    shadow_d [6];
  logic          do_it, scan_done, wr_ack;
  logic [7:0]    ad_out;
  logic          ad_oe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      scan_pend_q <= 1'b0;
      wr_pend_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      w_r_q       <= 1'b0;
      addr_q      <= '0;
      cap_q       <= '0;
      for (int i = 0; i < 6; i++) shadow_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      scan_pend_q <= scan_pend_d;
      wr_pend_q   <= wr_pend_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      w_r_q       <= w_r_d;
      addr_q      <= addr_d;
      cap_q       <= cap_d;
      for (int i = 0; i < 6; i++) shadow_q[i] <= shadow_d[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    scan_pend_d = scan_pend_q;
    wr_pend_d   = wr_pend_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    w_r_d       = w_r_q;
    addr_d      = addr_q;
    cap_d       = cap_q;
    shadow_d    = shadow_q;
    do_it       = 1'b0;
    scan_done   = 1'b0;
    wr_ack      = 1'b0;

    case (state_q)
      IDLE: begin
        if (wr_pend_q) begin
          w_r_d   = 1'b1;
          addr_d  = wr_addr_q;
          state_d = ISSUE;
        end else if (scan_pend_q) begin
          scan_pend_d = 1'b0;
          idx_d       = '0;
          w_r_d       = 1'b0;
          addr_d      = BASE_ADDR;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        do_it   = 1'b1;
        cnt_d   = CNT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (!w_r_q && bus.read_data) cap_d = bus.ad_in;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!w_r_q) begin
          shadow_d[idx_q] = cap_q;
          if (idx_q == 3'd5) begin
            scan_done = 1'b1;
            state_d   = IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            addr_d  = BASE_ADDR + 8'(idx_q) + 8'd1;
            state_d = ISSUE;
          end
        end else begin
          wr_ack    = 1'b1;
          wr_pend_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Request latching comes last so a new scan request is never lost to the IDLE clear
    if (bus.scan_req) scan_pend_d = 1'b1;
    if (bus.wr_req && !wr_pend_q) begin
      wr_pend_d = 1'b1;
      wr_addr_d = bus.wr_addr;
      wr_data_d = bus.wr_data;
    end
  end

  always_comb begin
    ad_out = '0;
    ad_oe  = 1'b0;
    if (bus.send_add) begin
      ad_out = addr_q;
      ad_oe  = 1'b1;
    end else if (bus.send_data && w_r_q) begin
      ad_out = wr_data_q;
      ad_oe  = 1'b1;
    end
  end

  assign bus.do_it     = do_it;
  assign bus.w_r       = w_r_q;
  assign bus.ad_out    = ad_out;
  assign bus.ad_oe     = ad_oe;
  assign bus.sec       = shadow_q[0];
  assign bus.min       = shadow_q[1];
  assign bus.hour      = shadow_q[2];
  assign bus.day       = shadow_q[3];
  assign bus.month     = shadow_q[4];
  assign bus.year      = shadow_q[5];
  assign bus.scan_done = scan_done;
  assign bus.wr_ack    = wr_ack;
  assign bus.wr_pend   = wr_pend_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_rtc_sequencer.sv
// tb/tb_rtc_sequencer.sv - directed bench for rtc_sequencer with a simple bus-cycle model
module tb_rtc_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;

  rtc_sequencer_if bus();

  rtc_sequencer #(.TXN_CYCLES(36), .BASE_ADDR(8'h21)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  int cyc = 0;
  int doit_cnt = 0;
  int done_cnt = 0;
  int ack_cnt = 0;
  int done_cyc = 0;
  int ack_cyc = 0;
  int doit_cyc[$];

  // Event log, sampled 1 time unit after each rising edge
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (bus.do_it) begin
      doit_cnt++;
      doit_cyc.push_back(cyc);
    end
    if (bus.scan_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.wr_ack) begin
      ack_cnt++;
      ack_cyc = cyc;
    end
  end

  logic [7:0] resp_ofs = 8'h10;
  logic [7:0] addr_log[$];
  logic       wr_log[$];
  logic [7:0] data_log[$];
  int         proto_bad = 0;
  logic       bm_wr;
  logic [7:0] bm_addr;

  // Bus-cycle model: address phase, then one write-data or read-data cycle
  initial begin
    bus.send_add  = 1'b0;
    bus.send_data = 1'b0;
    bus.read_data = 1'b0;
    bus.ad_in     = 8'hEE;
    forever begin
      @(posedge clk);
      #2;
      if (reset && bus.do_it) begin
        bm_wr = bus.w_r;
        @(posedge clk);
        #2;
        bus.send_add = 1'b1;
        @(posedge clk);
        #2;
        bm_addr = bus.ad_out;
        if (!bus.ad_oe || bus.w_r !== bm_wr) proto_bad++;
        bus.send_add = 1'b0;
        addr_log.push_back(bm_addr);
        wr_log.push_back(bm_wr);
        if (bm_wr) begin
          bus.send_data = 1'b1;
          @(posedge clk);
          #2;
          data_log.push_back(bus.ad_out);
          if (!bus.ad_oe || bus.w_r !== bm_wr) proto_bad++;
          bus.send_data = 1'b0;
        end else begin
          bus.ad_in     = bm_addr + resp_ofs;
          bus.read_data = 1'b1;
          @(posedge clk);
          #2;
          if (bus.ad_oe || bus.w_r !== bm_wr) proto_bad++;
          bus.read_data = 1'b0;
          bus.ad_in     = 8'hEE;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic wait_done(input int target, input int limit, input string tag);
    int k = 0;
    while (done_cnt < target && k < limit) begin
      tick(1);
      k++;
    end
    chk(tag, 32'(done_cnt >= target), 1);
  endtask

  task automatic wait_ack(input int target, input int limit, input string tag);
    int k = 0;
    while (ack_cnt < target && k < limit) begin
      tick(1);
      k++;
    end
    chk(tag, 32'(ack_cnt >= target), 1);
  endtask

  task automatic wait_doit(input int target, input int limit, input string tag);
    int k = 0;
    while (doit_cnt < target && k < limit) begin
      tick(1);
      k++;
    end
    chk(tag, 32'(doit_cnt >= target), 1);
  endtask

  task automatic chk_sh(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                        input logic [7:0] s2, input logic [7:0] s3,
                        input logic [7:0] s4, input logic [7:0] s5);
    chk({tag, " sec"},   bus.sec,   s0);
    chk({tag, " min"},   bus.min,   s1);
    chk({tag, " hour"},  bus.hour,  s2);
    chk({tag, " day"},   bus.day,   s3);
    chk({tag, " month"}, bus.month, s4);
    chk({tag, " year"},  bus.year,  s5);
  endtask

  task automatic pulse_scan();
    bus.scan_req = 1'b1;
    tick(1);
    bus.scan_req = 1'b0;
  endtask

  task automatic pulse_wr(input logic [7:0] a, input logic [7:0] d);
    bus.wr_addr = a;
    bus.wr_data = d;
    bus.wr_req  = 1'b1;
    tick(1);
    bus.wr_req  = 1'b0;
    bus.wr_addr = 8'h00;
    bus.wr_data = 8'h00;
  endtask

  int r_cyc;

  initial begin
    bus.scan_req = 1'b0;
    bus.wr_req   = 1'b0;
    bus.wr_addr  = 8'h00;
    bus.wr_data  = 8'h00;
    reset        = 1'b0;
    tick(3);

    chk("rst do_it", bus.do_it, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst ad_oe", bus.ad_oe, 0);
    chk("rst ad_out", bus.ad_out, 0);
    chk("rst w_r", bus.w_r, 0);
    chk("rst wr_pend", bus.wr_pend, 0);
    chk("rst scan_done", bus.scan_done, 0);
    chk("rst wr_ack", bus.wr_ack, 0);
    chk_sh("rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    reset = 1'b1;
    tick(2);
    chk("post-rst busy", bus.busy, 0);
    chk("post-rst do_it", bus.do_it, 0);
    chk("post-rst ad_oe", bus.ad_oe, 0);

    // Single scan, bus returns addr+10
    r_cyc = cyc;
    pulse_scan();
    wait_done(1, 400, "scan1 timeout");
    chk("scan1 busy at done", bus.busy, 1);
    tick(1);
    chk("scan1 busy after done", bus.busy, 0);
    chk("scan1 do_it count", doit_cnt, 6);
    chk("scan1 req to do_it", doit_cyc[0] - r_cyc, 2);
    chk("scan1 do_it spacing", doit_cyc[1] - doit_cyc[0], 37);
    chk("scan1 done latency", done_cyc - doit_cyc[0], 221);
    chk("scan1 done count", done_cnt, 1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("scan1 addr %0d", i), addr_log[i], 32'h21 + i);
      chk($sformatf("scan1 w_r %0d", i), wr_log[i], 0);
    end
    chk_sh("scan1", 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36);
    chk("scan1 protocol", proto_bad, 0);

    // Single write 22/45
    pulse_wr(8'h22, 8'h45);
    chk("wr1 pend set", bus.wr_pend, 1);
    wait_ack(1, 200, "wr1 timeout");
    chk("wr1 ack latency", ack_cyc - doit_cyc[6], 36);
    tick(1);
    chk("wr1 pend clear", bus.wr_pend, 0);
    chk("wr1 busy", bus.busy, 0);
    chk("wr1 w_r held", bus.w_r, 1);
    chk("wr1 addr", addr_log[6], 8'h22);
    chk("wr1 w_r", wr_log[6], 1);
    chk("wr1 data", data_log[0], 8'h45);
    chk("wr1 do_it count", doit_cnt, 7);
    chk("wr1 ack count", ack_cnt, 1);
    chk_sh("wr1", 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36);
    chk("wr1 protocol", proto_bad, 0);

    // Write during the 3rd read, plus a dropped second write
    resp_ofs = 8'h20;
    pulse_scan();
    wait_doit(10, 300, "mid do_it timeout");
    tick(3);
    pulse_wr(8'h23, 8'h09);
    chk("mid pend set", bus.wr_pend, 1);
    tick(5);
    pulse_wr(8'h24, 8'h77);
    wait_ack(2, 600, "mid ack timeout");
    chk("mid done count", done_cnt, 2);
    chk("mid scan before write", 32'(done_cyc < ack_cyc), 1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("mid addr %0d", i), addr_log[7 + i], 32'h21 + i);
      chk($sformatf("mid w_r %0d", i), wr_log[7 + i], 0);
    end
    chk("mid wr addr", addr_log[13], 8'h23);
    chk("mid wr w_r", wr_log[13], 1);
    chk("mid wr data", data_log[1], 8'h09);
    chk_sh("mid", 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46);
    tick(80);
    chk("mid single ack", ack_cnt, 2);
    chk("mid do_it count", doit_cnt, 14);

    // Simultaneous scan and write; then two merged scan requests
    resp_ofs = 8'h30;
    bus.scan_req = 1'b1;
    pulse_wr(8'h25, 8'h5A);
    bus.scan_req = 1'b0;
    wait_ack(3, 200, "sim ack timeout");
    chk("sim write first addr", addr_log[14], 8'h25);
    chk("sim write first w_r", wr_log[14], 1);
    chk("sim write data", data_log[2], 8'h5A);
    chk("sim no scan yet", done_cnt, 2);
    wait_doit(16, 50, "sim scan start timeout");
    tick(2);
    pulse_scan();
    tick(10);
    pulse_scan();
    wait_done(4, 1000, "sim scans timeout");
    tick(300);
    chk("sim done count", done_cnt, 4);
    chk("sim busy", bus.busy, 0);
    chk("sim do_it count", doit_cnt, 27);
    chk("sim scan addr", addr_log[15], 8'h21);
    chk("sim scan w_r", wr_log[15], 0);
    chk_sh("sim", 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56);

    // Reset during the 4th read's WAIT
    resp_ofs = 8'h40;
    pulse_scan();
    wait_doit(31, 300, "rst4 do_it timeout");
    tick(20);
    chk("rst4 busy before", bus.busy, 1);
    reset = 1'b0;
    tick(1);
    chk("rst4 busy", bus.busy, 0);
    chk("rst4 scan_done", bus.scan_done, 0);
    chk_sh("rst4", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    tick(1);
    reset = 1'b1;
    tick(40);
    chk("rst4 no done", done_cnt, 4);
    resp_ofs = 8'h50;
    pulse_scan();
    wait_done(5, 400, "rst4 rescan timeout");
    tick(2);
    chk_sh("rescan", 8'h71, 8'h72, 8'h73, 8'h74, 8'h75, 8'h76);
    chk("rescan wr_pend", bus.wr_pend, 0);
    chk("final protocol", proto_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
